sha256_chain_core: RTL and testbench

Parametrised SHA-256 compression engine with built-in multi-block chaining and a configurable number of rounds per clock. It succeeds the fixed single-block core. It accepts one 512-bit padded block per start and selects the initial state internally: FIPS IV, the previous digest, or an external value. It applies the feed-forward addition and presents the 256-bit digest with a one-cycle valid pulse. It sits between the message padder/block buffer and the digest consumer.

---
 rtl/sha256_chain_core.sv | 148 ++++++++++++++
 tb/tb_sha256_chain_core.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/sha256_chain_core.sv
// SHA-256 compression engine with internal initial-state selection (IV / chained digest / external)
// and ROUNDS_PER_CYCLE rounds unrolled per clock.
module sha256_chain_core #(
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         start_in,
    input  logic [1:0]   state_sel_in,
    input  logic [511:0] message_in,
    input  logic [255:0] state_in,
    output logic [255:0] state_out,
    output logic         valid_out,
    output logic         ready_out,
    output logic         busy_out
);

    localparam int R = ROUNDS_PER_CYCLE;

    if (!(R == 1 || R == 2 || R == 4 || R == 8 || R == 16)) begin : g_bad_rounds
        $error("sha256_chain_core: ROUNDS_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end

    localparam logic [5:0] LAST_CNT = 6'(64 - R);
    localparam logic [5:0] CNT_STEP = 6'(R);

    localparam logic [255:0] FIPS_IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

    localparam logic [31:0] K_ROM [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    typedef enum logic [1:0] {S_IDLE, S_ROUND, S_DONE} state_e;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // One round on a packed {a,b,c,d,e,f,g,h} working state, a in the top word.
    function automatic logic [255:0] round_fn(input logic [255:0] s, input logic [31:0] k,
                                              input logic [31:0] w);
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
        {a, b, c, d, e, f, g, h} = s;
        t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + k + w;
        t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
        return {t1 + t2, a, b, c, d + t1, e, f, g};
    endfunction

    // Next schedule word from the 16-word window, W[t-16] in the top word.
    function automatic logic [31:0] sched_fn(input logic [511:0] w);
        logic [31:0] w0, w1, w9, w14;
        w0  = w[511:480];
        w1  = w[479:448];
        w9  = w[223:192];
        w14 = w[63:32];
        return (rotr(w14, 17) ^ rotr(w14, 19) ^ (w14 >> 10)) + w9
             + (rotr(w1, 7) ^ rotr(w1, 18) ^ (w1 >> 3)) + w0;
    endfunction

    function automatic logic [255:0] ff_add(input logic [255:0] h, input logic [255:0] s);
        logic [255:0] r;
        for (int j = 0; j < 8; j++) r[32*j +: 32] = h[32*j +: 32] + s[32*j +: 32];
        return r;
    endfunction

    state_e        state_q, state_d;
    logic [511:0]  w_q, w_c;
    logic [255:0]  abc_q, s_c;
    logic [255:0]  hff_q;
    logic [255:0]  digest_q;
    logic [5:0]    cnt_q;
    logic [255:0]  init_state;
    logic          accept;
    logic          last;

    assign accept = start_in && (state_q != S_ROUND);
    assign last   = (state_q == S_ROUND) && (cnt_q == LAST_CNT);

    // The digest register doubles as the chain register, so chaining from DONE sees the value on state_out.
    always_comb begin
        case (state_sel_in)
            2'b01:   init_state = digest_q;
            2'b10:   init_state = state_in;
            default: init_state = FIPS_IV;
        endcase
    end

    always_comb begin
        s_c = abc_q;
        w_c = w_q;
        for (int k = 0; k < R; k++) begin
            s_c = round_fn(s_c, K_ROM[cnt_q + 6'(k)], w_c[511:480]);
            w_c = {w_c[479:0], sched_fn(w_c)};
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = accept ? S_ROUND : S_IDLE;
            S_ROUND: state_d = last ? S_DONE : S_ROUND;
            S_DONE:  state_d = accept ? S_ROUND : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ready_out = (state_q != S_ROUND);
        busy_out  = (state_q == S_ROUND);
        valid_out = (state_q == S_DONE);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            w_q      <= '0;
            abc_q    <= '0;
            hff_q    <= '0;
            digest_q <= '0;
            cnt_q    <= '0;
        end else if (accept) begin
            w_q   <= message_in;
            abc_q <= init_state;
            hff_q <= init_state;
            cnt_q <= '0;
        end else if (state_q == S_ROUND) begin
            w_q   <= w_c;
            abc_q <= s_c;
            cnt_q <= cnt_q + CNT_STEP;
            if (last) digest_q <= ff_add(hff_q, s_c);
        end
    end

    assign state_out = digest_q;

endmodule

// File: tb/tb_sha256_chain_core.sv
// Bench for sha256_chain_core: one instance per legal ROUNDS_PER_CYCLE, checked against
// known digests and a plain-arithmetic SHA-256 compression model.
module tb_sha256_chain_core;

    localparam int NI = 5;

    localparam logic [255:0] IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

    localparam logic [31:0] KT [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    localparam logic [511:0] ABC_BLK = {32'h61626380, {14{32'h0}}, 32'h00000018};
    localparam logic [255:0] ABC_DIG = {
        32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
        32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad};
    localparam logic [511:0] BLK1 = {
        32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
        32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam logic [511:0] BLK2 = {{15{32'h0}}, 32'h000001c0};
    localparam logic [255:0] TWO_DIG = {
        32'h248d6a61, 32'hd20638b8, 32'he5c02693, 32'h0c3e6039,
        32'ha33ce459, 32'h64ff2167, 32'hf6ecedd4, 32'h19db06c1};

    logic         CLK = 1'b0;
    logic         rst_n;
    logic         start_s [NI];
    logic [1:0]   sel_s   [NI];
    logic [511:0] msg_s   [NI];
    logic [255:0] sti_s   [NI];
    logic [255:0] sto_s   [NI];
    logic         vld_s   [NI];
    logic         rdy_s   [NI];
    logic         bsy_s   [NI];

    logic [255:0] exp_chain [NI];
    int n_chk = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        sha256_chain_core #(.ROUNDS_PER_CYCLE(1 << g)) u_dut (
            .CLK(CLK), .RST(rst_n),
            .start_in(start_s[g]), .state_sel_in(sel_s[g]),
            .message_in(msg_s[g]), .state_in(sti_s[g]),
            .state_out(sto_s[g]), .valid_out(vld_s[g]),
            .ready_out(rdy_s[g]), .busy_out(bsy_s[g]));
    end

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Textbook compression: full 64-word schedule array, then 64 rounds, then feed-forward.
    function automatic logic [255:0] sha_model(input logic [255:0] h, input logic [511:0] blk);
        logic [31:0] w [64];
        logic [31:0] v [8];
        logic [31:0] t1, t2;
        logic [255:0] r;
        for (int t = 0; t < 16; t++) w[t] = blk[511 - 32*t -: 32];
        for (int t = 16; t < 64; t++)
            w[t] = (ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
                 + (ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
        for (int j = 0; j < 8; j++) v[j] = h[255 - 32*j -: 32];
        for (int t = 0; t < 64; t++) begin
            t1 = v[7] + (ror(v[4], 6) ^ ror(v[4], 11) ^ ror(v[4], 25))
               + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[t] + w[t];
            t2 = (ror(v[0], 2) ^ ror(v[0], 13) ^ ror(v[0], 22))
               + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            for (int j = 7; j > 0; j--) v[j] = v[j-1];
            v[4] = v[4] + t1;
            v[0] = t1 + t2;
        end
        for (int j = 0; j < 8; j++) r[255 - 32*j -: 32] = h[255 - 32*j -: 32] + v[j];
        return r;
    endfunction

    function automatic logic [511:0] rnd512();
        logic [511:0] r;
        for (int j = 0; j < 16; j++) r[32*j +: 32] = $urandom();
        return r;
    endfunction

    function automatic logic [255:0] rnd256();
        logic [255:0] r;
        for (int j = 0; j < 8; j++) r[32*j +: 32] = $urandom();
        return r;
    endfunction

    function automatic logic [255:0] init_for(input int i, input logic [1:0] sel, input logic [255:0] st);
        if (sel == 2'b01) return exp_chain[i];
        if (sel == 2'b10) return st;
        return IV;
    endfunction

    // Called at a negedge with the instance ready; returns at the negedge of the DONE cycle.
    // lat counts cycles from the start cycle through the valid cycle inclusive.
    task automatic run_block(input int i, input logic [1:0] sel, input logic [511:0] msg,
                             input logic [255:0] st, input logic [255:0] exp, input bit poke,
                             output int lat);
        int rlow;
        int r;
        r = 1 << i;
        start_s[i] = 1'b1; sel_s[i] = sel; msg_s[i] = msg; sti_s[i] = st;
        @(negedge CLK);
        start_s[i] = 1'b0; sel_s[i] = 2'($urandom()); msg_s[i] = rnd512(); sti_s[i] = rnd256();
        lat = 2;
        rlow = 0;
        while (vld_s[i] !== 1'b1 && lat < 200) begin
            if (rdy_s[i] === 1'b0 && bsy_s[i] === 1'b1) rlow++;
            start_s[i] = poke && (lat == 12 || lat == 32);
            @(negedge CLK);
            lat++;
        end
        start_s[i] = 1'b0;
        chk($sformatf("latency_r%0d", r), lat, 64 / r + 2);
        chk($sformatf("ready_low_r%0d", r), rlow, 64 / r);
        chk($sformatf("done_ready_r%0d", r), {rdy_s[i], bsy_s[i]}, 2'b10);
        chk($sformatf("digest_r%0d", r), sto_s[i], exp);
        exp_chain[i] = exp;
    endtask

    initial begin
        int lat;
        logic [1:0] sel;
        logic [511:0] msg;
        logic [255:0] st, mid;

        rst_n = 1'b0;
        for (int i = 0; i < NI; i++) begin
            start_s[i] = 1'b0; sel_s[i] = 2'b00; msg_s[i] = '0; sti_s[i] = '0; exp_chain[i] = '0;
        end
        repeat (3) @(negedge CLK);
        for (int i = 0; i < NI; i++)
            chk($sformatf("reset_outs_%0d", i), {sto_s[i], vld_s[i], rdy_s[i], bsy_s[i]}, {256'h0, 3'b010});
        rst_n = 1'b1;
        @(negedge CLK);

        // "abc", R=1, followed by an idle cycle showing a single valid pulse.
        run_block(0, 2'b00, ABC_BLK, rnd256(), ABC_DIG, 1'b0, lat);
        @(negedge CLK);
        chk("abc_single_pulse", {vld_s[0], rdy_s[0]}, 2'b01);

        // Two-block chain at R=4, second block issued in the first block's DONE cycle.
        mid = sha_model(IV, BLK1);
        run_block(2, 2'b00, BLK1, rnd256(), mid, 1'b0, lat);
        run_block(2, 2'b01, BLK2, rnd256(), TWO_DIG, 1'b0, lat);
        chk("b2b_gap_r4", lat - 1, 17);

        // External intermediate state at R=16.
        run_block(4, 2'b10, BLK2, mid, TWO_DIG, 1'b0, lat);

        // Starts during ROUND must be ignored.
        @(negedge CLK);
        run_block(0, 2'b00, ABC_BLK, rnd256(), ABC_DIG, 1'b1, lat);
        @(negedge CLK);
        chk("busy_single_pulse", vld_s[0], 1'b0);

        // Asynchronous reset at about round 20, then a chained run from the zero state.
        start_s[0] = 1'b1; sel_s[0] = 2'b00; msg_s[0] = ABC_BLK;
        @(negedge CLK);
        start_s[0] = 1'b0;
        repeat (20) @(negedge CLK);
        #3 rst_n = 1'b0;
        #1 chk("async_reset_outs", {sto_s[0], vld_s[0], rdy_s[0], bsy_s[0]}, {256'h0, 3'b010});
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK);
            chk("reset_no_valid", vld_s[0], 1'b0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < NI; i++) exp_chain[i] = '0;
        @(negedge CLK);
        run_block(0, 2'b01, ABC_BLK, rnd256(), sha_model(256'h0, ABC_BLK), 1'b0, lat);

        // Random blocks and select sequences across every legal R.
        for (int i = 0; i < NI; i++) begin
            @(negedge CLK);
            for (int n = 0; n < 6; n++) begin
                sel = 2'($urandom_range(0, 3));
                msg = rnd512();
                st  = rnd256();
                run_block(i, sel, msg, st, sha_model(init_for(i, sel, st), msg), 1'b0, lat);
                if ($urandom_range(0, 1) == 1) begin
                    @(negedge CLK);
                    chk($sformatf("sweep_idle_r%0d", 1 << i), {vld_s[i], rdy_s[i], bsy_s[i]}, 3'b010);
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
